// File: rtl/usb_crc16_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_crc16_ctrl (with helper usb_crc16_step)
// Brief    : USB CRC16 controller: TX appends inverted CRC, RX checks it.
//            Optional error counter port enabled by macro USB_CRC16_STAT_EN.
// Revision : 1.0
// ============================================================================

module usb_crc16_step (
   input  logic [7:0]  data,
   input  logic [15:0] crc_in,
   output logic [15:0] crc_out
);
   localparam logic [15:0] c_poly_rev = 16'hA001;

   logic [15:0] w_crc;

   // LSB-first serial CRC unrolled over one byte
   always_comb begin
      w_crc = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (w_crc[0] ^ data[i]) w_crc = {1'b0, w_crc[15:1]} ^ c_poly_rev;
         else                    w_crc = {1'b0, w_crc[15:1]};
      end
      crc_out = w_crc;
   end
endmodule

module usb_crc16_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_sop,
   input  logic        in_eop,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_eop,
   output logic        crc_done,
   output logic        crc_ok,
   output logic [15:0] crc_value
`ifdef USB_CRC16_STAT_EN
  ,output logic [7:0]  err_cnt
`endif
);
   localparam logic [15:0] c_crc_init = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_APP_LO = 3'd2,
      ST_APP_HI = 3'd3,
      ST_CHECK  = 3'd4
   } state_t;

   state_t      r_state;
   logic        r_mode;
   logic [15:0] r_crc;
   logic [7:0]  r_dly_new;
   logic [7:0]  r_dly_old;
   logic [1:0]  r_dly_cnt;
   logic        r_lo_loaded;
   logic        r_out_valid;
   logic [7:0]  r_out_data;
   logic        r_out_eop;
   logic        r_crc_done;
   logic        r_crc_ok;

   logic        w_in_hs;
   logic        w_out_hs;
   logic        w_start;
   logic        w_tx;
   logic        w_rx_match;
   logic [7:0]  w_step_data;
   logic [15:0] w_step_crc_in;
   logic [15:0] w_step_crc_out;

   always_comb begin
      in_ready = 1'b0;
      if ((r_state == ST_IDLE) || (r_state == ST_DATA))
         in_ready = !r_out_valid || out_ready;
   end

   assign w_in_hs  = in_valid && in_ready;
   assign w_out_hs = r_out_valid && out_ready;
   assign w_start  = w_in_hs && in_sop;
   assign w_tx     = w_start ? mode : r_mode;

   // RX feeds the byte leaving the delay line; TX feeds the accepted byte
   assign w_step_crc_in = w_start ? c_crc_init : r_crc;
   assign w_step_data   = w_tx ? in_data : r_dly_old;

   // Last byte received is the high byte of the transmitted inverted CRC
   assign w_rx_match = (r_dly_cnt == 2'd2) && ({r_dly_new, r_dly_old} == ~r_crc);

   usb_crc16_step u_step (
      .data    (w_step_data),
      .crc_in  (w_step_crc_in),
      .crc_out (w_step_crc_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_crc       <= c_crc_init;
         r_dly_new   <= 8'h00;
         r_dly_old   <= 8'h00;
         r_dly_cnt   <= 2'd0;
         r_lo_loaded <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_eop   <= 1'b0;
         r_crc_done  <= 1'b0;
         r_crc_ok    <= 1'b0;
      end else begin
         r_crc_done <= 1'b0;
         if (w_out_hs) r_out_valid <= 1'b0;

         case (r_state)
            ST_IDLE, ST_DATA: begin
               if (w_in_hs && (in_sop || (r_state == ST_DATA))) begin
                  if (in_sop) r_mode <= mode;
                  if (w_tx) begin
                     r_crc       <= w_step_crc_out;
                     r_out_valid <= 1'b1;
                     r_out_data  <= in_data;
                     r_out_eop   <= 1'b0;
                     r_lo_loaded <= 1'b0;
                     r_state     <= in_eop ? ST_APP_LO : ST_DATA;
                  end else begin
                     if (in_sop) begin
                        r_crc     <= c_crc_init;
                        r_dly_old <= 8'h00;
                        r_dly_cnt <= 2'd1;
                     end else begin
                        if (r_dly_cnt == 2'd2) r_crc <= w_step_crc_out;
                        else                   r_dly_cnt <= r_dly_cnt + 2'd1;
                        r_dly_old <= r_dly_new;
                     end
                     r_dly_new <= in_data;
                     r_state   <= in_eop ? ST_CHECK : ST_DATA;
                  end
               end
            end

            // The eop payload byte drains first, then the low CRC byte loads
            ST_APP_LO: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b1;
                  if (!r_lo_loaded) begin
                     r_out_data  <= ~r_crc[7:0];
                     r_lo_loaded <= 1'b1;
                  end else begin
                     r_out_data <= ~r_crc[15:8];
                     r_out_eop  <= 1'b1;
                     r_state    <= ST_APP_HI;
                  end
               end
            end

            ST_APP_HI: begin
               if (w_out_hs) begin
                  r_out_eop <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end

            ST_CHECK: begin
               r_crc_done <= 1'b1;
               r_crc_ok   <= w_rx_match;
               r_state    <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef USB_CRC16_STAT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_cnt <= 8'h00;
      else if ((r_state == ST_CHECK) && !w_rx_match && (r_err_cnt != 8'hFF))
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign err_cnt = r_err_cnt;
`endif

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_eop   = r_out_eop;
   assign crc_done  = r_crc_done;
   assign crc_ok    = r_crc_ok;
   assign crc_value = r_crc;
endmodule

`default_nettype wire

// File: tb/tb_usb_crc16_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_crc16_ctrl
// Brief    : Self-checking bench for usb_crc16_ctrl against a CRC-16/USB model.
// Revision : 1.0
// ============================================================================
module tb_usb_crc16_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_eop;
   logic        crc_done;
   logic        crc_ok;
   logic [15:0] crc_value;
`ifdef USB_CRC16_STAT_EN
   logic [7:0]  err_cnt;
   int          exp_err = 0;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  pkt[$];
   logic [7:0]  cap_d[$];
   logic        cap_e[$];
   int          done_cnt = 0;
   logic        last_ok = 1'b0;
   int          hold_viol = 0;
   logic        prev_v = 1'b0;
   logic        prev_r = 1'b0;
   logic        prev_e = 1'b0;
   logic [7:0]  prev_d = 8'h00;
   logic        rand_rdy = 1'b0;

   always #5 clk = ~clk;

   usb_crc16_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_eop   (out_eop),
      .crc_done  (crc_done),
      .crc_ok    (crc_ok),
      .crc_value (crc_value)
`ifdef USB_CRC16_STAT_EN
     ,.err_cnt   (err_cnt)
`endif
   );

   // Mid-cycle observer: output handshakes, done pulses, stall stability
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (prev_v && !prev_r &&
             (!out_valid || out_data !== prev_d || out_eop !== prev_e))
            hold_viol++;
         if (out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_e.push_back(out_eop);
         end
         if (crc_done) begin
            done_cnt++;
            last_ok = crc_ok;
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = out_data;
         prev_e = out_eop;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reflected CRC-16/USB computed as MSB-first 0x8005 on bit-reversed data
   function automatic logic [15:0] model_crc(input int cnt);
      logic [15:0] c;
      logic [15:0] r;
      logic [7:0]  rb;
      c = 16'hFFFF;
      for (int i = 0; i < cnt; i++) begin
         for (int b = 0; b < 8; b++) rb[b] = pkt[i][7-b];
         c = c ^ {rb, 8'h00};
         for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
      end
      for (int b = 0; b < 16; b++) r[b] = c[15-b];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop, input logic md);
      int guard;
      guard = 0;
      in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; mode = md;
      #1;
      while (!in_ready && guard < 200) begin
         tick();
         guard++;
      end
      chk("in_ready_wait", in_ready, 1);
      tick();
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic send_pkt(input logic md);
      for (int i = 0; i < pkt.size(); i++)
         send_byte(pkt[i], i == 0, i == pkt.size() - 1, md);
   endtask

   task automatic append_crc();
      logic [15:0] c;
      c = ~model_crc(pkt.size());
      pkt.push_back(c[7:0]);
      pkt.push_back(c[15:8]);
   endtask

   task automatic rx_run(input string tag);
      int d0, n, guard;
      logic [15:0] exp_crc, word;
      logic exp_ok;
      n = pkt.size();
      exp_crc = 16'hFFFF;
      exp_ok = 1'b0;
      if (n >= 2) begin
         exp_crc = model_crc(n - 2);
         word = {pkt[n-1], pkt[n-2]};
         exp_ok = (word == ~exp_crc);
      end
      cap_d.delete(); cap_e.delete();
      d0 = done_cnt;
      send_pkt(1'b0);
      guard = 0;
      while (done_cnt == d0 && guard < 8) begin
         tick();
         guard++;
      end
      tick(); tick();
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_ok"}, last_ok, exp_ok);
      chk({tag, "_okhold"}, crc_ok, exp_ok);
      chk({tag, "_crc"}, crc_value, exp_crc);
      chk({tag, "_noout"}, cap_d.size(), 0);
`ifdef USB_CRC16_STAT_EN
      if (!exp_ok && exp_err < 255) exp_err++;
      chk({tag, "_errcnt"}, err_cnt, exp_err);
`endif
   endtask

   task automatic tx_run(input string tag);
      int n, guard;
      logic [15:0] exp_crc;
      logic [7:0] e;
      n = pkt.size();
      exp_crc = model_crc(n);
      cap_d.delete(); cap_e.delete();
      send_pkt(1'b1);
      guard = 0;
      while (cap_d.size() < n + 2 && guard < 300) begin
         tick();
         guard++;
      end
      tick(); tick();
      chk({tag, "_len"}, cap_d.size(), n + 2);
      for (int i = 0; i < n + 2 && i < cap_d.size(); i++) begin
         if (i < n)       e = pkt[i];
         else if (i == n) e = ~exp_crc[7:0];
         else             e = ~exp_crc[15:8];
         chk($sformatf("%s_byte%0d", tag, i), cap_d[i], e);
         chk($sformatf("%s_eop%0d", tag, i), cap_e[i], i == n + 1);
      end
      chk({tag, "_crc"}, crc_value, exp_crc);
      chk({tag, "_hold"}, hold_viol, 0);
   endtask

   initial begin
      int d0, len;
      logic [15:0] lo_crc;
      logic [7:0] lo_byte;

      // Reset values while reset is asserted
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_eop", out_eop, 0);
      chk("rst_crc_done", crc_done, 0);
      chk("rst_crc_ok", crc_ok, 0);
      chk("rst_crc_value", crc_value, 16'hFFFF);
`ifdef USB_CRC16_STAT_EN
      chk("rst_err_cnt", err_cnt, 8'h00);
`endif
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", in_ready, 1);

      pkt = '{8'h00, 8'h00};        rx_run("rx_zero_ok");
      pkt = '{8'h00, 8'h01};        rx_run("rx_zero_bad");
      pkt = '{8'hA5};               rx_run("rx_single");

      // Byte without sop in IDLE is dropped
      d0 = done_cnt;
      send_byte(8'h33, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      chk("drop_no_done", done_cnt - d0, 0);

      // CRC-16/USB of "123456789" is 0xB4C8
      pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      tx_run("tx_ascii");
      chk("tx_ascii_lo", cap_d[9], 8'hC8);
      chk("tx_ascii_hi", cap_d[10], 8'hB4);
      pkt = cap_d;                  rx_run("rx_ascii");

      pkt = '{8'h01, 8'h02, 8'h03}; tx_run("tx_123");
      pkt = cap_d;                  rx_run("rx_123_loop");

      // Output stall during APP_LO
      rand_rdy = 1'b0;
      out_ready = 1'b0;
      pkt = '{8'h5A};
      lo_crc = ~model_crc(1);
      lo_byte = lo_crc[7:0];
      cap_d.delete(); cap_e.delete();
      send_pkt(1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("stall_valid%0d", i), out_valid, 1);
         chk($sformatf("stall_data%0d", i), out_data, lo_byte);
         chk($sformatf("stall_inrdy%0d", i), in_ready, 0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 20 && cap_d.size() < 3; i++) tick();
      chk("stall_len", cap_d.size(), 3);
      if (cap_d.size() == 3) begin
         chk("stall_b0", cap_d[0], 8'h5A);
         chk("stall_b1", cap_d[1], lo_byte);
         chk("stall_b2", cap_d[2], lo_crc[15:8]);
         chk("stall_eop", cap_e[2], 1);
      end
      chk("stall_hold", hold_viol, 0);

      // Abort: sop arriving in DATA restarts the packet
      send_byte(8'h11, 1'b1, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0, 1'b0);
      pkt = '{8'h9C, 8'h4E, 8'hD7};
      append_crc();
      rx_run("rx_abort");
      send_byte(8'hAA, 1'b1, 1'b0, 1'b1);
      send_byte(8'hBB, 1'b0, 1'b0, 1'b1);
      tick();
      pkt = '{8'hC3, 8'h3C};
      tx_run("tx_abort");

      // Randomized TX packets looped back into RX, some corrupted
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 8);
         pkt.delete();
         for (int j = 0; j < len; j++) pkt.push_back(8'($urandom_range(0, 255)));
         rand_rdy = 1'b1;
         tx_run($sformatf("tx_rand%0d", it));
         pkt = cap_d;
         if (it % 2 == 1) begin
            int k;
            k = $urandom_range(0, pkt.size() - 1);
            pkt[k] = pkt[k] ^ 8'(1 << $urandom_range(0, 7));
         end
         rx_run($sformatf("rx_rand%0d", it));
      end
      rand_rdy = 1'b0;

      // Reset mid-TX packet
      out_ready = 1'b1;
      send_byte(8'h77, 1'b1, 1'b0, 1'b1);
      send_byte(8'h88, 1'b0, 1'b0, 1'b1);
      out_ready = 1'b0;
      #1;
      chk("mid_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_crc", crc_value, 16'hFFFF);
      chk("mid_rst_data", out_data, 8'h00);
      tick();
      rst_n = 1'b1;
      cap_d.delete(); cap_e.delete();
      d0 = done_cnt;
      out_ready = 1'b1;
      repeat (10) tick();
      chk("mid_after_out", cap_d.size(), 0);
      chk("mid_after_done", done_cnt - d0, 0);
      chk("mid_after_crc", crc_value, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/usb_crc16_ctrl.md
USB_CRC16_CTRL -- requirements
Module: usb_crc16_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port mode, input, 1, 1=TX generate / 0=RX check, sampled on SOP handshake.
REQ-004 SHALL have ports in_valid/in_ready, input/output, 1 each, input byte handshake.
REQ-005 SHALL have ports in_data (input, 8, payload byte), in_sop (input, 1, first byte), in_eop (input, 1, last byte).
REQ-006 SHALL have ports out_valid/out_ready, output/input, 1 each, TX output byte handshake.
REQ-007 SHALL have ports out_data (output, 8, TX byte) and out_eop (output, 1, last TX byte).
REQ-008 SHALL have ports crc_done (output, 1, one-cycle RX-check pulse) and crc_ok (output, 1, result, valid with crc_done).
REQ-009 SHALL have port crc_value, output, 16, current CRC register.

Function
REQ-010 SHALL instantiate one crc16 byte-step datapath (data, crc_in -> crc_out); all CRC updates go through it, one byte per cycle max.
REQ-011 SHALL implement states IDLE, DATA, APP_LO, APP_HI, CHECK.
REQ-012 Handshake = valid&&ready same cycle; in IDLE/DATA, in_ready = !out_valid || out_ready; in_ready=0 in APP_LO, APP_HI, CHECK.
REQ-013 IDLE: accepted byte with in_sop -> CRC reg = 0xFFFF then stepped per mode; mode latched; -> DATA (or end-of-packet handling if in_eop same cycle); bytes without in_sop dropped.
REQ-014 TX DATA: each accepted byte steps CRC and is registered to out_data/out_valid next cycle (latency 1); out_eop=0 for payload.
REQ-015 TX eop byte accepted -> APP_LO: out_data=~crc[7:0]; on out handshake -> APP_HI: out_data=~crc[15:8], out_eop=1; on handshake -> IDLE.
REQ-016 out_valid/out_data/out_eop SHALL hold stable while out_valid && !out_ready.
REQ-017 RX: out_valid stays 0; bytes pass a 2-byte delay line; a byte steps CRC only when pushed out by a newer byte, so the final two bytes never enter the CRC.
REQ-018 RX eop byte accepted -> CHECK; next cycle crc_done=1, crc_ok = ({last, second-last} == ~crc) with last byte as high byte; -> IDLE.
REQ-019 RX packet of <2 bytes SHALL give crc_done=1, crc_ok=0.
REQ-020 in_sop accepted in DATA SHALL abort current packet (no crc_done, no CRC append) and restart as in REQ-013.
REQ-021 crc_ok SHALL hold its value until next crc_done; crc_value reflects register every cycle.

Reset
REQ-022 rst_n low SHALL force immediately: state IDLE, CRC reg 0xFFFF, delay line 0, out_valid 0, out_data 0x00, out_eop 0, crc_done 0, crc_ok 0.
REQ-023 Reset mid-packet SHALL discard the packet; no CRC bytes or crc_done emitted afterwards.

Configuration
REQ-024 Macro USB_CRC16_STAT_EN defined: adds output err_cnt (8 bits, reset 0), +1 on each crc_done with crc_ok=0, saturating at 0xFF.
REQ-025 Macro undefined: no err_cnt port or counter logic; all other behaviour identical.

Verification
REQ-026 RX sop 0x00, eop 0x00 -> one cycle after eop: crc_done=1, crc_ok=1.
REQ-027 RX sop 0x00, eop 0x01 -> crc_done=1, crc_ok=0 (err_cnt 0->1 with USB_CRC16_STAT_EN).
REQ-028 RX single byte 0xA5 with sop+eop -> crc_done=1, crc_ok=0.
REQ-029 TX 0x01 0x02 0x03 looped into RX -> TX emits 5 bytes, out_eop on 5th; RX crc_ok=1.
REQ-030 TX with out_ready held low 5 cycles during APP_LO -> out_data constant, in_ready=0, no byte lost.
REQ-031 rst_n pulse after 2 TX payload bytes -> out_valid=0 at once, crc_value=0xFFFF, no appended bytes.
